// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of mem_port_arbiter: two request channels (A, B) and the shared read return.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int PSIZE = 4
);
  logic             a_req;
  logic             a_we;
  logic [PSIZE-1:0] a_addr;
  logic [WIDTH-1:0] a_wdata;
  logic             a_gnt;
  logic             a_rvalid;

  logic             b_req;
  logic             b_we;
  logic [PSIZE-1:0] b_addr;
  logic [WIDTH-1:0] b_wdata;
  logic             b_gnt;
  logic             b_rvalid;

  logic [WIDTH-1:0] rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin two-requester arbiter in front of a single-port register memory.
// Optional post-reset/on-demand zero sweep enabled by defining MEM_ARB_CLEAR_EN.
module mem_port_arbiter #(
  parameter int WIDTH = 16,
  parameter int PSIZE = 4,
  parameter int DEPTH = 2**PSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave bus,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [PSIZE-1:0] mem_wr_addr,
  output logic [PSIZE-1:0] mem_rd_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             clear_req,
  output logic             busy
);

  localparam int HW = WIDTH / 2;
  localparam logic [PSIZE-1:0] HALF_ADDR = PSIZE'(DEPTH / 2);

  typedef enum logic {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;

`ifdef MEM_ARB_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
  localparam logic [PSIZE-1:0] LAST_ADDR = PSIZE'(DEPTH - 1);
`else
  localparam state_t RESET_STATE = ST_ARB;
`endif

  state_t           state_reg, state_next;
  logic             last_b_reg;
  logic             a_gnt_c, b_gnt_c, clearing, grant;
  logic [PSIZE-1:0] clr_addr;

  logic             sel_b, sel_we, sel_upper;
  logic [PSIZE-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata, sel_wdata_swapped;

  logic             mem_wr_reg, mem_rd_reg, rd_tag_reg;
  logic [PSIZE-1:0] mem_wr_addr_reg, mem_rd_addr_reg;
  logic [WIDTH-1:0] mem_wdata_reg;
  logic             a_rvalid_reg, b_rvalid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RESET_STATE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
`ifdef MEM_ARB_CLEAR_EN
    case (state_reg)
      ST_ARB:   if (clear_req) state_next = ST_CLEAR;
      ST_CLEAR: if (clr_addr == LAST_ADDR) state_next = ST_ARB;
      default:  state_next = ST_ARB;
    endcase
`else
    state_next = ST_ARB;
`endif
  end

  // Ties go to whichever requester did not win last; grants are suppressed while sweeping.
  always_comb begin
    clearing = 1'b0;
    a_gnt_c  = 1'b0;
    b_gnt_c  = 1'b0;
    case (state_reg)
      ST_CLEAR: clearing = 1'b1;
      default: begin
        a_gnt_c = bus.a_req & (~bus.b_req | last_b_reg);
        b_gnt_c = bus.b_req & ~a_gnt_c;
      end
    endcase
  end

`ifdef MEM_ARB_CLEAR_EN
  logic [PSIZE-1:0] clr_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   clr_cnt_reg <= '0;
    else if (state_reg == ST_CLEAR) clr_cnt_reg <= clr_cnt_reg + 1'b1;
    else                          clr_cnt_reg <= '0;
  end

  assign clr_addr = clr_cnt_reg;
`else
  logic unused_clear_req;

  assign unused_clear_req = clear_req;
  assign clr_addr         = '0;
`endif

  assign grant = a_gnt_c | b_gnt_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_b_reg <= 1'b1;
    else if (grant) last_b_reg <= b_gnt_c;
  end

  assign sel_b     = b_gnt_c;
  assign sel_we    = sel_b ? bus.b_we    : bus.a_we;
  assign sel_addr  = sel_b ? bus.b_addr  : bus.a_addr;
  assign sel_wdata = sel_b ? bus.b_wdata : bus.a_wdata;
  assign sel_upper = (sel_addr >= HALF_ADDR);
  // The memory swaps halves of upper-half words; swapping here makes the round trip flat.
  assign sel_wdata_swapped = {sel_wdata[HW-1:0], sel_wdata[WIDTH-1:HW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_reg      <= 1'b0;
      mem_rd_reg      <= 1'b0;
      mem_wr_addr_reg <= '0;
      mem_rd_addr_reg <= '0;
      mem_wdata_reg   <= '0;
      rd_tag_reg      <= 1'b0;
      a_rvalid_reg    <= 1'b0;
      b_rvalid_reg    <= 1'b0;
    end else begin
      mem_wr_reg <= 1'b0;
      mem_rd_reg <= 1'b0;
      if (clearing) begin
        mem_wr_reg      <= 1'b1;
        mem_wr_addr_reg <= clr_addr;
        mem_wdata_reg   <= '0;
      end else if (grant) begin
        if (sel_we) begin
          mem_wr_reg      <= 1'b1;
          mem_wr_addr_reg <= sel_addr;
          mem_wdata_reg   <= sel_upper ? sel_wdata_swapped : sel_wdata;
        end else begin
          mem_rd_reg      <= 1'b1;
          mem_rd_addr_reg <= sel_addr;
          rd_tag_reg      <= sel_b;
        end
      end
      // Memory output is registered, so read data appears one cycle after mem_rd.
      a_rvalid_reg <= mem_rd_reg & ~rd_tag_reg;
      b_rvalid_reg <= mem_rd_reg & rd_tag_reg;
    end
  end

  assign bus.a_gnt    = a_gnt_c;
  assign bus.b_gnt    = b_gnt_c;
  assign bus.a_rvalid = a_rvalid_reg;
  assign bus.b_rvalid = b_rvalid_reg;
  assign bus.rdata    = mem_rdata;
  assign mem_wr       = mem_wr_reg;
  assign mem_rd       = mem_rd_reg;
  assign mem_wr_addr  = mem_wr_addr_reg;
  assign mem_rd_addr  = mem_rd_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign busy         = clearing;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: flat-memory reference model, command/read-return queues,
// and a behavioural model of the half-swapping memory macro.
module tb_mem_port_arbiter;
  localparam int WIDTH = 16;
  localparam int PSIZE = 4;
  localparam int DEPTH = 16;
`ifdef MEM_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_req = 1'b0;
  logic mem_wr, mem_rd, busy;
  logic [PSIZE-1:0] mem_wr_addr, mem_rd_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter_if #(.WIDTH(WIDTH), .PSIZE(PSIZE)) bus();

  mem_port_arbiter #(.WIDTH(WIDTH), .PSIZE(PSIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .clear_req(clear_req), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory macro: stores upper-half words with halves swapped, registered read port.
  logic [WIDTH-1:0] mem_arr [DEPTH];
  logic [WIDTH-1:0] mem_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= '0;
    end else begin
      if (mem_wr)
        mem_arr[mem_wr_addr] <= (mem_wr_addr >= 4'd8) ? {mem_wdata[7:0], mem_wdata[15:8]} : mem_wdata;
      if (mem_rd) mem_q <= mem_arr[mem_rd_addr];
    end
  end
  assign mem_rdata = mem_q;

  typedef struct { int due; bit wr; logic [3:0] addr; logic [15:0] data; } cmd_t;
  typedef struct { int due; bit who_b; logic [15:0] data; } rv_t;
  cmd_t cmdq[$];
  rv_t  rvq[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  // Reference model: the flat memory the requesters should see, plus the arbitration rule.
  logic [15:0] flat [DEPTH];
  bit last_winner_b, m_clearing, a_done, b_done;
  int m_clr_addr;

  always @(negedge clk) begin : model
    bit ga, gb, we, who;
    logic [3:0] addr;
    logic [15:0] d;
    if (!rst_n) begin
      cmdq.delete(); rvq.delete();
      last_winner_b = 1'b1; m_clearing = CLR_EN; m_clr_addr = 0;
      a_done = 1'b0; b_done = 1'b0;
      for (int i = 0; i < DEPTH; i++) flat[i] = 16'h0;
    end else begin
      ga = 1'b0; gb = 1'b0;
      if (!m_clearing) begin
        if (bus.a_req && bus.b_req) begin
          if (last_winner_b) ga = 1'b1; else gb = 1'b1;
        end else begin
          ga = bus.a_req; gb = bus.b_req;
        end
      end
      check("a_gnt", bus.a_gnt, ga);
      check("b_gnt", bus.b_gnt, gb);
      check("busy", busy, m_clearing);
      if (ga || gb) begin
        who  = gb;
        we   = who ? bus.b_we : bus.a_we;
        addr = who ? bus.b_addr : bus.a_addr;
        d    = who ? bus.b_wdata : bus.a_wdata;
        if (we) begin
          cmdq.push_back('{cyc + 1, 1'b1, addr, (addr >= 4'd8) ? {d[7:0], d[15:8]} : d});
          flat[addr] = d;
          $display("cycle %0d: %s write addr %0d data %h", cyc, who ? "B" : "A", addr, d);
        end else begin
          cmdq.push_back('{cyc + 1, 1'b0, addr, 16'h0});
          rvq.push_back('{cyc + 2, who, flat[addr]});
          $display("cycle %0d: %s read  addr %0d expect %h", cyc, who ? "B" : "A", addr, flat[addr]);
        end
        last_winner_b = who;
      end
      if (m_clearing) begin
        cmdq.push_back('{cyc + 1, 1'b1, 4'(m_clr_addr), 16'h0});
        if (m_clr_addr == DEPTH - 1) begin m_clearing = 1'b0; m_clr_addr = 0; end
        else m_clr_addr++;
      end else if (clear_req && CLR_EN) begin
        m_clearing = 1'b1; m_clr_addr = 0;
        for (int i = 0; i < DEPTH; i++) flat[i] = 16'h0;
        $display("cycle %0d: clear sweep requested", cyc);
      end
      a_done = ga; b_done = gb;
    end
  end

  // Monitor: compares memory commands and read returns against the queued expectations.
  always @(negedge clk) begin : monitor
    cmd_t c;
    rv_t r;
    if (!rst_n) begin
      check("rst_mem_cmd", {mem_wr, mem_rd}, 2'b00);
      check("rst_rvalid", {bus.a_rvalid, bus.b_rvalid}, 2'b00);
      check("rst_rdata", bus.rdata, 16'h0);
    end else begin
      check("wr_rd_exclusive", mem_wr & mem_rd, 1'b0);
      if (cmdq.size() > 0 && cmdq[0].due == cyc) begin
        c = cmdq.pop_front();
        check("cmd_kind", {mem_wr, mem_rd}, c.wr ? 2'b10 : 2'b01);
        if (c.wr) begin
          check("mem_wr_addr", mem_wr_addr, c.addr);
          check("mem_wdata", mem_wdata, c.data);
        end else begin
          check("mem_rd_addr", mem_rd_addr, c.addr);
        end
      end else begin
        check("no_cmd", {mem_wr, mem_rd}, 2'b00);
      end
      if (rvq.size() > 0 && rvq[0].due == cyc) begin
        r = rvq.pop_front();
        check("rvalid", {bus.a_rvalid, bus.b_rvalid}, r.who_b ? 2'b01 : 2'b10);
        check("rdata", bus.rdata, r.data);
      end else begin
        check("no_rvalid", {bus.a_rvalid, bus.b_rvalid}, 2'b00);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    clear_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 64) begin tick(); n++; end
    check("busy_timeout", busy, 1'b0);
  endtask

  task automatic set_req(input bit is_b, input bit we, input logic [3:0] addr, input logic [15:0] d);
    if (is_b) begin bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = d; end
    else      begin bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = d; end
  endtask

  task automatic do_req(input bit is_b, input bit we, input logic [3:0] addr, input logic [15:0] d);
    int n = 0;
    bit done;
    set_req(is_b, we, addr, d);
    do begin
      tick(); n++;
      done = is_b ? b_done : a_done;
    end while (!done && n < 100);
    check(is_b ? "b_grant_timeout" : "a_grant_timeout", done, 1'b1);
    if (is_b) bus.b_req = 1'b0; else bus.a_req = 1'b0;
  endtask

  task automatic rand_req(input bit is_b);
    set_req(is_b, 1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)), 16'($urandom));
    if ($urandom_range(0, 3) == 0) begin
      if (is_b) bus.b_req = 1'b0; else bus.a_req = 1'b0;
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    wait_idle();
    do_req(1'b0, 1'b0, 4'd5, 16'h0);
    do_req(1'b0, 1'b1, 4'd3, 16'h1234);
    do_req(1'b0, 1'b0, 4'd3, 16'h0);
    do_req(1'b1, 1'b1, 4'd12, 16'hABCD);
    do_req(1'b1, 1'b0, 4'd12, 16'h0);
    // Both requesters busy for several cycles: grants must alternate.
    rand_req(1'b0); rand_req(1'b1);
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_done) begin rand_req(1'b0); bus.a_req = 1'b1; end
      if (b_done) begin rand_req(1'b1); bus.b_req = 1'b1; end
    end
    idle();
    tick();
    // Write then same-address read from the other requester on the very next cycle.
    do_req(1'b0, 1'b1, 4'd7, 16'h7E57);
    do_req(1'b1, 1'b0, 4'd7, 16'h0);
    // Read in flight when the sweep is requested in the same cycle.
    do_req(1'b0, 1'b1, 4'd9, 16'h5555);
    set_req(1'b0, 1'b0, 4'd9, 16'h0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    bus.a_req = 1'b0;
    check("clr_cycle_grant", a_done, 1'b1);
    wait_idle();
    do_req(1'b0, 1'b0, 4'd9, 16'h0);
    // Randomised traffic, occasional clear requests.
    for (int i = 0; i < 400; i++) begin
      if (!bus.a_req || a_done) rand_req(1'b0);
      if (!bus.b_req || b_done) rand_req(1'b1);
      clear_req = ($urandom_range(0, 99) == 0);
      tick();
    end
    idle();
    wait_idle();
    // Reset while a read is in flight: its return must be dropped.
    set_req(1'b0, 1'b0, 4'd3, 16'h0);
    tick();
    bus.a_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_idle();
    set_req(1'b0, 1'b0, 4'd1, 16'h0);
    set_req(1'b1, 1'b0, 4'd2, 16'h0);
    tick();
    check("tie_after_reset_a_first", a_done, 1'b1);
    tick();
    idle();
    repeat (5) tick();
    check("scoreboard_drained", cmdq.size() + rvq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
